// File: rtl/wb2core.sv
// Wishbone B4 pipelined slave that converts bus cycles into a req/gnt/rvalid core memory port.
// Tracks outstanding transfers and drains abandoned responses after an aborted Wishbone cycle.
module wb2core #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [3:0]           wb_sel,
  input  logic [AddrWidth-1:0] wb_adr,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack,
  output logic                 wb_err,
  output logic                 wb_stall,
  output logic                 core_req,
  input  logic                 core_gnt,
  input  logic                 core_rvalid,
  output logic                 core_we,
  output logic [3:0]           core_be,
  output logic [AddrWidth-1:0] core_addr,
  output logic [31:0]          core_wdata,
  input  logic [31:0]          core_rdata,
  input  logic                 core_err
);

  localparam logic [3:0] CntMax = 4'(MaxOutstanding);

  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 drain_q, drain_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          dat_q, dat_d;

  logic acc;
  logic rv;
  logic resp;

  always_comb begin
    wb_stall = (req_q & ~core_gnt) | (cnt_q == CntMax) | drain_q;
    acc      = wb_cyc & wb_stb & ~wb_stall;
    // A response with nothing outstanding is a protocol violation and is dropped.
    rv       = core_rvalid & (cnt_q != 4'd0);
    resp     = rv & ~drain_q & wb_cyc;

    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (acc) begin
      req_d   = 1'b1;
      we_d    = wb_we;
      be_d    = wb_sel;
      addr_d  = wb_adr & ~AddrWidth'(3);
      wdata_d = wb_dat_i;
    end else if (core_gnt) begin
      req_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (acc && !rv) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!acc && rv) begin
      cnt_d = cnt_q - 4'd1;
    end

    drain_d = drain_q;
    if (!wb_cyc && cnt_q != 4'd0) begin
      drain_d = 1'b1;
    end
    if (cnt_d == 4'd0) begin
      drain_d = 1'b0;
    end

    ack_d = resp & ~core_err;
    err_d = resp & core_err;
    dat_d = (resp && !core_err) ? core_rdata : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      cnt_q   <= 4'd0;
      drain_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign core_req   = req_q;
  assign core_we    = we_q;
  assign core_be    = be_q;
  assign core_addr  = addr_q;
  assign core_wdata = wdata_q;
  assign wb_ack     = ack_q;
  assign wb_err     = err_q;
  assign wb_dat_o   = dat_q;

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (req_q && !core_gnt) |=> (req_q && $stable({we_q, be_q, addr_q, wdata_q})));

  a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntMax);

  a_no_resp_drain: assert property (@(posedge clk) disable iff (rst)
    drain_q |-> !(ack_q || err_q));

  a_one_resp: assert property (@(posedge clk) disable iff (rst) !(ack_q && err_q));

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
    core_rvalid |-> (cnt_q != 4'd0));

endmodule
